// File: rtl/array_reverse_mailbox_if.sv
// Handshake bundle for the thread-slotted lane-reversal mailbox.
// The master side issues write and read requests; the slave side returns data, flags and error pulses.
interface array_reverse_mailbox_if #(
    parameter int unsigned WORD_WIDTH   = 36,
    parameter int unsigned LANE_COUNT   = 8,
    parameter int unsigned THREAD_WIDTH = 3
);
    logic [WORD_WIDTH*LANE_COUNT-1:0] in;
    logic [LANE_COUNT-1:0]            in_wren;
    logic [LANE_COUNT-1:0]            in_full;
    logic [WORD_WIDTH*LANE_COUNT-1:0] out;
    logic [LANE_COUNT-1:0]            out_rden;
    logic [LANE_COUNT-1:0]            out_empty;
    logic [THREAD_WIDTH-1:0]          thread;
    logic [LANE_COUNT-1:0]            overflow;
    logic [LANE_COUNT-1:0]            underflow;

    modport master (
        output in, in_wren, out_rden,
        input  in_full, out, out_empty, thread, overflow, underflow
    );

    modport slave (
        input  in, in_wren, out_rden,
        output in_full, out, out_empty, thread, overflow, underflow
    );
endinterface

// File: rtl/array_reverse_mailbox.sv
// Thread-slotted lane-reversal buffer: a word written on lane i by thread t is read back
// on lane LANE_COUNT-1-i by the same thread on a later turn, with per-lane full/empty handshaking.
module array_reverse_mailbox #(
    parameter int unsigned WORD_WIDTH   = 36,
    parameter int unsigned LANE_COUNT   = 8,
    parameter int unsigned THREAD_COUNT = 8,
    parameter int unsigned THREAD_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    array_reverse_mailbox_if.slave bus
);
    localparam int unsigned LAST_THREAD = THREAD_COUNT - 1;

    logic [WORD_WIDTH-1:0]            data  [THREAD_COUNT][LANE_COUNT];
    logic [LANE_COUNT-1:0]            valid [THREAD_COUNT];
    logic [THREAD_WIDTH-1:0]          thread_q;
    logic [WORD_WIDTH*LANE_COUNT-1:0] out_q;
    logic [LANE_COUNT-1:0]            overflow_q;
    logic [LANE_COUNT-1:0]            underflow_q;

    // Cell-indexed: cur_valid, wr_ok, rd_ok, next_valid. Lane-indexed: wr_refused, rd_refused.
    logic [LANE_COUNT-1:0] cur_valid;
    logic [LANE_COUNT-1:0] wr_ok;
    logic [LANE_COUNT-1:0] rd_ok;
    logic [LANE_COUNT-1:0] wr_refused;
    logic [LANE_COUNT-1:0] rd_refused;
    logic [LANE_COUNT-1:0] next_valid;

    // Arbitration against pre-edge occupancy; a write and a read on the same cell never both succeed.
    always_comb begin
        cur_valid  = valid[thread_q];
        wr_ok      = '0;
        rd_ok      = '0;
        wr_refused = '0;
        rd_refused = '0;
        for (int unsigned c = 0; c < LANE_COUNT; c++) begin
            wr_ok[c]                       = bus.in_wren[LANE_COUNT-1-c] && !cur_valid[c];
            wr_refused[LANE_COUNT-1-c]     = bus.in_wren[LANE_COUNT-1-c] &&  cur_valid[c];
            rd_ok[c]                       = bus.out_rden[c] &&  cur_valid[c];
            rd_refused[c]                  = bus.out_rden[c] && !cur_valid[c];
        end
        next_valid = (cur_valid & ~rd_ok) | wr_ok;
    end

    // Handshake flags for the current thread's slot.
    always_comb begin
        bus.in_full = '0;
        for (int unsigned i = 0; i < LANE_COUNT; i++) begin
            bus.in_full[i] = cur_valid[LANE_COUNT-1-i];
        end
        bus.out_empty = ~cur_valid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            thread_q    <= '0;
            out_q       <= '0;
            overflow_q  <= '0;
            underflow_q <= '0;
            for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
                valid[t] <= '0;
            end
        end else begin
            thread_q        <= (thread_q == THREAD_WIDTH'(LAST_THREAD)) ? '0
                                                                        : thread_q + THREAD_WIDTH'(1);
            valid[thread_q] <= next_valid;
            overflow_q      <= wr_refused;
            underflow_q     <= rd_refused;
            for (int unsigned j = 0; j < LANE_COUNT; j++) begin
                if (rd_ok[j]) begin
                    out_q[j*WORD_WIDTH +: WORD_WIDTH] <= data[thread_q][j];
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is readable.
    always_ff @(posedge clock) begin
        for (int unsigned c = 0; c < LANE_COUNT; c++) begin
            if (wr_ok[c]) begin
                data[thread_q][c] <= bus.in[(LANE_COUNT-1-c)*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.thread    = thread_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_array_reverse_mailbox.sv
// Bench for array_reverse_mailbox: an 8-lane/8-thread instance and a 5-lane/5-thread instance
// run side by side against a per-cell mailbox reference model.
module tb_array_reverse_mailbox;
    localparam int unsigned W = 36;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst8;
    logic rst5;

    array_reverse_mailbox_if #(.WORD_WIDTH(W), .LANE_COUNT(8), .THREAD_WIDTH(3)) bus8 ();
    array_reverse_mailbox_if #(.WORD_WIDTH(W), .LANE_COUNT(5), .THREAD_WIDTH(3)) bus5 ();

    array_reverse_mailbox #(.WORD_WIDTH(W), .LANE_COUNT(8), .THREAD_COUNT(8), .THREAD_WIDTH(3))
        dut8 (.clock(clock), .reset(rst8), .bus(bus8.slave));
    array_reverse_mailbox #(.WORD_WIDTH(W), .LANE_COUNT(5), .THREAD_COUNT(5), .THREAD_WIDTH(3))
        dut5 (.clock(clock), .reset(rst5), .bus(bus5.slave));

    int vectors     = 0;
    int miscompares = 0;
    bit pre_chk_en  = 1'b0;

    // Reference model: index 0 is the 8-lane instance, index 1 the 5-lane instance.
    logic [W-1:0]   m_data  [2][8][8];
    bit             m_valid [2][8][8];
    int             m_thread[2];
    logic [287:0]   m_out   [2];
    logic [7:0]     m_ovf   [2];
    logic [7:0]     m_unf   [2];

    logic [287:0]   s_in  [2];
    logic [7:0]     s_wr  [2];
    logic [7:0]     s_rd  [2];
    logic           s_rst [2];

    function automatic int size_of(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            s_in[k]  = '0;
            s_wr[k]  = '0;
            s_rd[k]  = '0;
            s_rst[k] = 1'b0;
        end
    endtask

    task automatic model_update(input int k);
        int n, t, c;
        bit v[8];
        n = size_of(k);
        t = m_thread[k];
        if (s_rst[k]) begin
            m_thread[k] = 0;
            m_out[k]    = '0;
            m_ovf[k]    = '0;
            m_unf[k]    = '0;
            for (int a = 0; a < 8; a++)
                for (int b = 0; b < 8; b++) m_valid[k][a][b] = 1'b0;
        end else begin
            for (int x = 0; x < 8; x++) v[x] = m_valid[k][t][x];
            m_ovf[k] = '0;
            m_unf[k] = '0;
            for (int i = 0; i < n; i++) begin
                c = n - 1 - i;
                if (s_wr[k][i]) begin
                    if (v[c]) m_ovf[k][i] = 1'b1;
                    else begin
                        m_data[k][t][c]  = s_in[k][i*W +: W];
                        m_valid[k][t][c] = 1'b1;
                    end
                end
            end
            for (int j = 0; j < n; j++) begin
                if (s_rd[k][j]) begin
                    if (v[j]) begin
                        m_out[k][j*W +: W] = m_data[k][t][j];
                        m_valid[k][t][j]   = 1'b0;
                    end else m_unf[k][j] = 1'b1;
                end
            end
            m_thread[k] = (t + 1) % n;
        end
    endtask

    // One clock: drive both instances, check pre-edge flags, advance model, check registered outputs.
    task automatic cycle();
        logic [7:0] ef, ee;
        int n, t;
        @(negedge clock);
        bus8.in       = s_in[0];
        bus8.in_wren  = s_wr[0];
        bus8.out_rden = s_rd[0];
        rst8          = s_rst[0];
        bus5.in       = s_in[1][179:0];
        bus5.in_wren  = s_wr[1][4:0];
        bus5.out_rden = s_rd[1][4:0];
        rst5          = s_rst[1];
        #1;
        for (int k = 0; k < 2; k++) begin
            n  = size_of(k);
            t  = m_thread[k];
            ef = '0;
            ee = '0;
            for (int i = 0; i < n; i++) begin
                ef[i] = m_valid[k][t][n-1-i];
                ee[i] = !m_valid[k][t][i];
            end
            if (pre_chk_en) begin
                chk($sformatf("in_full[%0d]", k),
                    (k == 0) ? 288'(bus8.in_full) : 288'(bus5.in_full), 288'(ef));
                chk($sformatf("out_empty[%0d]", k),
                    (k == 0) ? 288'(bus8.out_empty) : 288'(bus5.out_empty), 288'(ee));
            end
            model_update(k);
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out[%0d]", k), (k == 0) ? bus8.out : 288'(bus5.out), m_out[k]);
            chk($sformatf("overflow[%0d]", k),
                (k == 0) ? 288'(bus8.overflow) : 288'(bus5.overflow), 288'(m_ovf[k]));
            chk($sformatf("underflow[%0d]", k),
                (k == 0) ? 288'(bus8.underflow) : 288'(bus5.underflow), 288'(m_unf[k]));
            chk($sformatf("thread[%0d]", k),
                (k == 0) ? 288'(bus8.thread) : 288'(bus5.thread), 288'(m_thread[k]));
        end
        pre_chk_en = 1'b1;
    endtask

    task automatic step(input int k, input logic [287:0] d, input logic [7:0] wr,
                        input logic [7:0] rd, input logic rst);
        idle_all();
        s_in[k]  = d;
        s_wr[k]  = wr;
        s_rd[k]  = rd;
        s_rst[k] = rst;
        cycle();
    endtask

    task automatic goto_thread(input int k, input int t);
        for (int i = 0; i < 8 && m_thread[k] != t; i++) step(k, '0, '0, '0, 1'b0);
    endtask

    logic [287:0] d;
    logic [287:0] expv;

    initial begin
        idle_all();
        s_rst[0] = 1'b1;
        s_rst[1] = 1'b1;
        cycle();
        cycle();

        // Idle run: thread counts up and wraps on both instances.
        for (int i = 0; i < 9; i++) step(0, '0, '0, '0, 1'b0);

        // Full reversal on thread 2.
        goto_thread(0, 2);
        d = '0;
        for (int i = 0; i < 8; i++) d[i*W +: W] = W'(32'h100 + i);
        step(0, d, 8'hFF, 8'h00, 1'b0);
        goto_thread(0, 2);
        step(0, '0, 8'h00, 8'hFF, 1'b0);
        expv = '0;
        for (int j = 0; j < 8; j++) expv[j*W +: W] = W'(32'h100 + 7 - j);
        chk("reversal_const", bus8.out, expv);
        goto_thread(0, 2);

        // Isolation: only thread 0 can see its own lane-0 write.
        goto_thread(0, 0);
        d = '0;
        d[0 +: W] = W'(32'hAAA);
        step(0, d, 8'h01, 8'h00, 1'b0);
        for (int t = 1; t < 8; t++) step(0, '0, 8'h00, 8'h80, 1'b0);
        step(0, '0, 8'h00, 8'h80, 1'b0);
        chk("isolation_const", 288'(bus8.out[7*W +: W]), 288'(32'hAAA));

        // Overflow on a full cell keeps the original word.
        goto_thread(0, 3);
        d = '0;
        d[1*W +: W] = W'(5);
        step(0, d, 8'h02, 8'h00, 1'b0);
        goto_thread(0, 3);
        d[1*W +: W] = W'(9);
        step(0, d, 8'h02, 8'h00, 1'b0);
        chk("overflow_const", 288'(bus8.overflow), 288'(8'h02));
        goto_thread(0, 3);
        step(0, '0, 8'h00, 8'h40, 1'b0);
        chk("overflow_keep_const", 288'(bus8.out[6*W +: W]), 288'(5));

        // Same-cell write and read, first with the cell full, then empty.
        goto_thread(0, 5);
        d = '0;
        d[0 +: W] = W'(32'h11);
        step(0, d, 8'h01, 8'h00, 1'b0);
        goto_thread(0, 5);
        d[0 +: W] = W'(32'h22);
        step(0, d, 8'h01, 8'h80, 1'b0);
        chk("simul_full_const", 288'(bus8.out[7*W +: W]), 288'(32'h11));
        goto_thread(0, 5);
        step(0, d, 8'h01, 8'h80, 1'b0);
        chk("simul_empty_const", 288'(bus8.underflow), 288'(8'h80));
        goto_thread(0, 5);
        step(0, '0, 8'h00, 8'h80, 1'b0);
        chk("simul_hold_const", 288'(bus8.out[7*W +: W]), 288'(32'h22));

        // Reset mid-operation with reads pending.
        goto_thread(0, 4);
        d = '0;
        for (int i = 0; i < 8; i++) d[i*W +: W] = W'(32'h400 + i);
        step(0, d, 8'hFF, 8'h00, 1'b0);
        goto_thread(0, 4);
        step(0, '0, 8'h00, 8'hFF, 1'b1);
        chk("reset_pulses_const", 288'({bus8.overflow, bus8.underflow}), 288'(0));
        for (int i = 0; i < 8; i++) step(0, '0, 8'h00, 8'h00, 1'b0);

        // Odd lane count: middle lane maps to itself.
        goto_thread(1, 1);
        d = '0;
        d[2*W +: W] = W'(32'h3C);
        step(1, d, 8'h04, 8'h00, 1'b0);
        goto_thread(1, 1);
        step(1, '0, 8'h00, 8'h04, 1'b0);
        chk("odd_mid_const", 288'(bus5.out[2*W +: W]), 288'(32'h3C));
        goto_thread(1, 4);
        step(1, '0, 8'h00, 8'h00, 1'b0);

        // Randomised traffic on both instances with occasional resets.
        for (int r = 0; r < 400; r++) begin
            for (int k = 0; k < 2; k++) begin
                for (int b = 0; b < 9; b++) s_in[k][b*32 +: 32] = $urandom;
                s_wr[k]  = 8'($urandom);
                s_rd[k]  = 8'($urandom);
                s_rst[k] = ($urandom_range(0, 63) == 0);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
